demux_1_2_4b: RTL
=================

Name: demux_1_2_4b

Overview:
- 1-to-2 registered demultiplexer: the inverse of the 2:1 mux used in the CPU datapath.
- Routes one source word to one of two destinations, selected by `in_sel`, using valid/ready handshakes on all three sides.
- Each destination has a one-entry output register, so a stalled destination never blocks traffic to the other.
- Sits between the ALU/result bus and the two write targets (accumulator path, register-file path).

Parameters:
- WIDTH, 4, data word width in bits.
- CNT_W, 8, width of each per-output delivered-beat counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  source presents a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  source word
- in_sel  input  1  destination select: 0 routes to out0, 1 routes to out1
- out0_valid  output  1  out0 register holds a word
- out0_ready  input  1  destination 0 consumes the word
- out0_data  output  WIDTH  out0 word
- out1_valid  output  1  out1 register holds a word
- out1_ready  input  1  destination 1 consumes the word
- out1_data  output  WIDTH  out1 word
- out0_cnt  output  CNT_W  words delivered on out0
- out1_cnt  output  CNT_W  words delivered on out1

Behaviour:
- Reset:
  - While rst_n=0 at a rising edge: outN_valid=0, outN_data=0, outN_cnt=0.
  - Reset mid-operation discards held words; no handshake is reported that cycle.
- in_ready is combinational: in_ready = !outS_valid || outS_ready, where S=in_sel. It never depends on the unselected output.
- Accept:
  - Occurs when in_valid && in_ready.
  - outS_data <= in_data and outS_valid <= 1 on that edge.
  - Latency is 1 cycle from accept to outS_valid=1.
- Source rule:
  - in_data and in_sel must be held stable while in_valid=1 and in_ready=0.
  - If in_sel changes anyway, in_ready is recomputed against the new selection.
  - Only the value sampled at accept matters.
- Drain:
  - When outN_valid && outN_ready: outN_cnt <= outN_cnt + 1, wrapping (2^CNT_W-1 -> 0).
  - If no refill occurs that cycle, outN_valid <= 0.
- Simultaneous drain and refill of the same output in one cycle:
  - outN_valid stays 1, outN_data takes the new word, and the counter increments.
  - Full throughput: one word per cycle per output.
- Accept into one output while the other drains is independent; both take effect on the same edge.
- outN_data holds its last value while outN_valid=0 (not cleared).
- outN_ready while outN_valid=0 has no effect.
- in_valid=0: no state change except drains.
- No per-output FSM beyond the valid bit. Each slot has two states:
  - EMPTY: to FULL on accept.
  - FULL: to EMPTY on drain without refill; stays FULL on drain with refill or with no drain.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W=4.
  - Select encoding constants SEL_OUT0=1'b0, SEL_OUT1=1'b1.
- Sub-module out_slot, instantiated twice:
  - Contains the one-entry register, valid bit, ready/drain logic and wrapping counter.
  - Ports: clk, rst_n, load, load_data, valid, ready, data, cnt, can_load.
- Top level holds:
  - Select decode: load0 = accept && sel==0, load1 = accept && sel==1.
  - in_ready mux.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with out0_ready=out1_ready=1 -> all valids 0, data 0, counts 0, in_ready=1.
- Single routed words:
  - in_data=4'hA, in_sel=0, one-cycle valid -> next cycle out0_valid=1, out0_data=A, out1_valid=0.
  - out0_ready=1 -> out0_cnt=1, out0_valid=0 following cycle.
  - Repeat with 4'h5, sel=1 -> out1_data=5, out1_cnt=1.
- Backpressure isolation: out0_ready=0 holding 4'h3; send 4'h7 sel=0 -> in_ready=0. Switch source to 4'h9 sel=1 -> in_ready=1, out1_data=9 next cycle, out0_data still 3.
- Full throughput: out0_ready=1, stream 4'h0..4'hF sel=0 back-to-back -> in_ready=1 every cycle, out0_data follows input by 1 cycle, out0_cnt=16 after drain.
- Counter wrap: 256 words to out1 -> out1_cnt returns to 0; out0_cnt unchanged.
- Reset mid-operation: out0 holding 4'hC with out0_ready=0, assert rst_n=0 one cycle -> out0_valid=0, out0_cnt=0, no delivery counted.

Source files
------------

// File: rtl/demux_1_2_4b_pkg.sv
// Shared definitions for the 1:2 result-bus demultiplexer.
package demux_1_2_4b_pkg;

   localparam int DATA_W = 4;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_1_2_4b_if.sv
// Source and destination handshake bundle for the 1:2 demultiplexer.
interface demux_1_2_4b_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic [CNT_W-1:0] out0_cnt;
   logic [CNT_W-1:0] out1_cnt;

   modport master (
      output in_valid, in_data, in_sel, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
             out0_cnt, out1_cnt
   );

   modport slave (
      input  in_valid, in_data, in_sel, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data,
             out0_cnt, out1_cnt
   );
endinterface

// File: rtl/demux_1_2_4b_out_slot.sv
// One-entry output register with valid/ready drain and a wrapping delivered-beat counter.
//
// state      | meaning
// SLOT_EMPTY | no word held; any load is accepted
// SLOT_FULL  | word held; waits for ready, may be refilled on the drain cycle
module demux_1_2_4b_out_slot
   import demux_1_2_4b_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic             can_load
);
   slot_state_t state;
   logic        drain;

   assign valid    = (state == SLOT_FULL);
   assign drain    = valid && ready;
   assign can_load = !valid || ready;

   // data is deliberately left untouched on drain so it holds while empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
         data  <= '0;
         cnt   <= '0;
      end else begin
         if (drain) cnt <= cnt + CNT_W'(1);
         unique case (state)
            SLOT_EMPTY: begin
               if (load) begin
                  state <= SLOT_FULL;
                  data  <= load_data;
               end
            end
            SLOT_FULL: begin
               if (load) data <= load_data;
               else if (drain) state <= SLOT_EMPTY;
            end
            default: state <= SLOT_EMPTY;
         endcase
      end
   end
endmodule

// File: rtl/demux_1_2_4b.sv
// 1:2 registered demultiplexer from the result bus to the accumulator and register-file paths.
module demux_1_2_4b
   import demux_1_2_4b_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   demux_1_2_4b_if.slave       bus
);
   logic can0;
   logic can1;
   logic accept;
   logic load0;
   logic load1;

   // in_ready only looks at the selected slot, so a stalled destination never blocks the other
   assign bus.in_ready = (bus.in_sel == SEL_OUT1) ? can1 : can0;
   assign accept       = bus.in_valid && bus.in_ready;
   assign load0        = accept && (bus.in_sel == SEL_OUT0);
   assign load1        = accept && (bus.in_sel == SEL_OUT1);

   demux_1_2_4b_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load0),
      .load_data (bus.in_data),
      .valid     (bus.out0_valid),
      .ready     (bus.out0_ready),
      .data      (bus.out0_data),
      .cnt       (bus.out0_cnt),
      .can_load  (can0)
   );

   demux_1_2_4b_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load1),
      .load_data (bus.in_data),
      .valid     (bus.out1_valid),
      .ready     (bus.out1_ready),
      .data      (bus.out1_data),
      .cnt       (bus.out1_cnt),
      .can_load  (can1)
   );
endmodule
